// File: rtl/pc_redirect_ctrl.sv
// Fetch PC owner and control-flow sequencer for the 5-stage core.
// Static predict-not-taken: every EX redirect squashes IF/ID and refetches.
//
// state  | meaning
// -------+-----------------------------------------------------------
// BOOT   | one idle cycle after reset, no fetch, PC held at RESET_PC
// RUN    | normal sequential fetch, honours stall / imem back-pressure
// SQUASH | cycle after a redirect; wrong-path word entering IF/ID killed
// FAULT  | misaligned redirect target seen; fetch stopped until rst
module pc_redirect_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ex_valid,
  input  logic             ex_branch,
  input  logic             ex_jump,
  input  logic [31:0]      ex_pc_plus4,
  input  logic [31:0]      ex_target,
  input  logic             stall,
  input  logic             imem_ready,
  output logic [31:0]      if_pc,
  output logic             fetch_req,
  output logic             flush_if,
  output logic             flush_id,
  output logic             fault,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] redirect_count
);

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    SQUASH = 2'd2,
    FAULT  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t      state;
  state_t      state_nxt;
  logic [31:0] pc_nxt;
  logic        active;
  logic        redirect;
  logic        misalign;
  logic        br_inc;
  logic        redirect_inc;

  always_comb begin
    active   = (state == RUN) || (state == SQUASH);
    redirect = active & ex_valid &
               (ex_jump | (ex_branch & (ex_target != ex_pc_plus4)));
    misalign = redirect & (ex_target[1:0] != 2'b00);
    br_inc       = active & ex_valid & ex_branch;
    redirect_inc = redirect & ~misalign;
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = if_pc;
    fetch_req = 1'b0;
    flush_if  = 1'b0;
    flush_id  = 1'b0;
    fault     = 1'b0;
    unique case (state)
      BOOT: begin
        state_nxt = RUN;
      end
      RUN, SQUASH: begin
        fetch_req = 1'b1;
        // SQUASH kills the word fetched during the redirect cycle
        flush_if  = (state == SQUASH) | redirect;
        flush_id  = redirect;
        if (misalign) begin
          state_nxt = FAULT;
        end else if (redirect) begin
          state_nxt = SQUASH;
          pc_nxt    = ex_target;
        end else begin
          state_nxt = RUN;
          if (!stall && imem_ready) begin
            pc_nxt = if_pc + 32'd4;
          end
        end
      end
      FAULT: begin
        flush_if = 1'b1;
        flush_id = 1'b1;
        fault    = 1'b1;
      end
      default: begin
        state_nxt = BOOT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= BOOT;
      if_pc <= RESET_PC;
    end else begin
      state <= state_nxt;
      if_pc <= pc_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      br_count       <= '0;
      redirect_count <= '0;
    end else begin
      if (br_inc) begin
        br_count <= br_count + CNT_ONE;
      end
      if (redirect_inc) begin
        redirect_count <= redirect_count + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Scoreboard bench for pc_redirect_ctrl: directed plan sequences then random traffic.
module tb_pc_redirect_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_branch, ex_jump;
  logic [31:0] ex_pc_plus4, ex_target;
  logic        stall, imem_ready;
  logic [31:0] if_pc;
  logic        fetch_req, flush_if, flush_id, fault;
  logic [31:0] br_count, redirect_count;

  pc_redirect_ctrl #(.RESET_PC(32'h0000_0000), .CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_branch(ex_branch), .ex_jump(ex_jump),
    .ex_pc_plus4(ex_pc_plus4), .ex_target(ex_target),
    .stall(stall), .imem_ready(imem_ready),
    .if_pc(if_pc), .fetch_req(fetch_req), .flush_if(flush_if),
    .flush_id(flush_id), .fault(fault),
    .br_count(br_count), .redirect_count(redirect_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic        freq;
    logic        fif;
    logic        fid;
    logic        flt;
    logic [31:0] bc;
    logic [31:0] rc;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model: the core is either booting, faulted, fetching, and
  // may owe one extra IF squash after a redirect.
  bit          m_booting;
  bit          m_faulted;
  bit          m_owe_squash;
  logic [31:0] m_pc;
  logic [31:0] m_bc;
  logic [31:0] m_rc;

  task automatic model_reset();
    m_booting    = 1;
    m_faulted    = 0;
    m_owe_squash = 0;
    m_pc         = 32'h0;
    m_bc         = 0;
    m_rc         = 0;
  endtask

  // Drive one cycle of inputs, predict this cycle's outputs, advance the model.
  task automatic step(input bit r, input bit v, input bit b, input bit j,
                      input logic [31:0] p4, input logic [31:0] tg,
                      input bit s, input bit rd);
    exp_t e;
    bit   fetching, takes, bad_tgt;
    rst = r; ex_valid = v; ex_branch = b; ex_jump = j;
    ex_pc_plus4 = p4; ex_target = tg; stall = s; imem_ready = rd;
    fetching = !m_booting && !m_faulted;
    takes    = fetching && v && (j || (b && tg != p4));
    bad_tgt  = takes && (tg % 4 != 0);
    e.pc   = m_pc;
    e.freq = fetching;
    e.fif  = m_faulted || takes || (fetching && m_owe_squash);
    e.fid  = m_faulted || takes;
    e.flt  = m_faulted;
    e.bc   = m_bc;
    e.rc   = m_rc;
    exp_q.push_back(e);
    if (r) begin
      model_reset();
    end else if (m_booting) begin
      m_booting = 0;
    end else if (!m_faulted) begin
      if (v && b) m_bc = m_bc + 1;
      if (bad_tgt) begin
        m_faulted = 1;
      end else if (takes) begin
        m_pc = tg;
        m_rc = m_rc + 1;
        m_owe_squash = 1;
      end else begin
        m_owe_squash = 0;
        if (!s && rd) m_pc = m_pc + 4;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 32'h0, 32'h0, 0, 1);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("if_pc", if_pc, e.pc);
      chk("fetch_req", {31'b0, fetch_req}, {31'b0, e.freq});
      chk("flush_if", {31'b0, flush_if}, {31'b0, e.fif});
      chk("flush_id", {31'b0, flush_id}, {31'b0, e.fid});
      chk("fault", {31'b0, fault}, {31'b0, e.flt});
      chk("br_count", br_count, e.bc);
      chk("redirect_count", redirect_count, e.rc);
    end
  end

  initial begin
    logic [31:0] p4, tg;
    int wait_cycles;
    rst = 1; ex_valid = 0; ex_branch = 0; ex_jump = 0;
    ex_pc_plus4 = 0; ex_target = 0; stall = 0; imem_ready = 1;
    @(posedge clk);
    #1;
    model_reset();
    step(1, 0, 0, 0, 0, 0, 0, 1);
    idle(3);
    // stall twice, back-pressure once
    step(0, 0, 0, 0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    idle(2);
    // taken branch
    step(0, 1, 1, 0, 32'h14, 32'h100, 0, 1);
    idle(2);
    // not-taken branch, then jump beating stall and back-pressure
    step(0, 1, 1, 0, 32'h20, 32'h20, 0, 1);
    step(0, 1, 0, 1, 32'h30, 32'h200, 1, 0);
    idle(2);
    // back-to-back redirects
    step(0, 1, 0, 1, 32'h210, 32'h40, 0, 1);
    step(0, 1, 0, 1, 32'h44, 32'h80, 0, 1);
    idle(2);
    // misaligned JALR then frozen for 10 cycles under noisy inputs
    step(0, 1, 0, 1, 32'h90, 32'h102, 0, 1);
    for (int i = 0; i < 10; i++)
      step(0, 1, $urandom_range(0, 1), $urandom_range(0, 1), $urandom, $urandom, 0, 1);
    step(1, 0, 0, 0, 0, 0, 0, 1);
    idle(3);
    // reset in the middle of SQUASH
    step(0, 1, 1, 0, 32'h10, 32'h300, 0, 1);
    step(1, 0, 0, 0, 0, 0, 0, 1);
    idle(3);
    // random traffic
    for (int i = 0; i < 3000; i++) begin
      p4 = {$urandom_range(0, 255), 2'b00};
      case ($urandom_range(0, 9))
        0, 1, 2: tg = p4;
        3:       tg = $urandom;
        default: tg = {$urandom_range(0, 255), 2'b00};
      endcase
      step(m_faulted ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 199) == 0),
           $urandom_range(0, 2) != 0, $urandom_range(0, 1), $urandom_range(0, 5) == 0,
           p4, tg, $urandom_range(0, 4) == 0, $urandom_range(0, 4) != 0);
    end
    // PC wrap at the top of the address space
    step(0, 1, 0, 1, 32'h0, 32'hFFFF_FFF8, 0, 1);
    idle(4);
    wait_cycles = 0;
    while (exp_q.size() > 0 && wait_cycles < 10) begin
      @(posedge clk);
      wait_cycles++;
    end
    if (exp_q.size() > 0) begin
      bad++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
